// File: rtl/frame_color_analyzer_pkg.sv
// Shared types and constants for the frame colour analyser: colour codes,
// FSM state encoding, default frame size and RGB444 field positions.
package frame_color_analyzer_pkg;

    typedef enum logic [1:0] {
        COLOR_NONE  = 2'd0,
        COLOR_RED   = 2'd1,
        COLOR_GREEN = 2'd2,
        COLOR_BLUE  = 2'd3
    } color_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int NPIX_DEFAULT = 19200;

    localparam int R_HI = 11;
    localparam int R_LO = 8;
    localparam int G_HI = 7;
    localparam int G_LO = 4;
    localparam int B_HI = 3;
    localparam int B_LO = 0;

endpackage

// File: rtl/frame_color_analyzer_pixel_classifier.sv
// Combinational RGB444 pixel classifier: a channel is dominant when it reaches
// the threshold and leads each other channel by at least the margin.
module pixel_classifier
    import frame_color_analyzer_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic [DW-1:0] pixel_i,
    input  logic [3:0]    thresh_i,
    input  logic [3:0]    margin_i,
    output color_e        class_o
);

    logic [4:0] r5_s;
    logic [4:0] g5_s;
    logic [4:0] b5_s;
    logic [4:0] t5_s;
    logic [4:0] m5_s;
    logic       is_r_s;
    logic       is_g_s;
    logic       is_b_s;

    // Five-bit operands so channel plus margin cannot wrap.
    always_comb begin
        r5_s   = {1'b0, pixel_i[R_HI:R_LO]};
        g5_s   = {1'b0, pixel_i[G_HI:G_LO]};
        b5_s   = {1'b0, pixel_i[B_HI:B_LO]};
        t5_s   = {1'b0, thresh_i};
        m5_s   = {1'b0, margin_i};
        is_r_s = (r5_s >= t5_s) && (r5_s >= g5_s + m5_s) && (r5_s >= b5_s + m5_s);
        is_g_s = (g5_s >= t5_s) && (g5_s >= r5_s + m5_s) && (g5_s >= b5_s + m5_s);
        is_b_s = (b5_s >= t5_s) && (b5_s >= r5_s + m5_s) && (b5_s >= g5_s + m5_s);
        if (is_r_s) begin
            class_o = COLOR_RED;
        end else if (is_g_s) begin
            class_o = COLOR_GREEN;
        end else if (is_b_s) begin
            class_o = COLOR_BLUE;
        end else begin
            class_o = COLOR_NONE;
        end
    end

endmodule

// File: rtl/frame_color_analyzer.sv
// Scans the frame buffer processing port once per start request, counts
// red/green/blue dominant pixels and reports the frame's dominant colour.
module frame_color_analyzer
    import frame_color_analyzer_pkg::*;
#(
    parameter int AW        = 15,
    parameter int DW        = 12,
    parameter int NPIX      = NPIX_DEFAULT,
    parameter int THRESH    = 8,
    parameter int MARGIN    = 2,
    parameter int MIN_COUNT = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic [AW-1:0] proc_addr_in,
    input  logic [DW-1:0] proc_data_in,
    output logic          busy,
    output logic          done,
    output logic [1:0]    color,
    output logic [AW-1:0] cnt_r,
    output logic [AW-1:0] cnt_g,
    output logic [AW-1:0] cnt_b
);

    localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
    localparam logic [AW-1:0] MINC = AW'(MIN_COUNT);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] wr_q, wr_d, wg_q, wg_d, wb_q, wb_d;
    logic [AW-1:0] cnt_r_q, cnt_r_d, cnt_g_q, cnt_g_d, cnt_b_q, cnt_b_d;
    logic [1:0]    color_q, color_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    color_e        pix_class_s;
    color_e        color_sel_s;
    logic          last_s;

    pixel_classifier #(.DW(DW)) u_classifier (
        .pixel_i  (proc_data_in),
        .thresh_i (4'(THRESH)),
        .margin_i (4'(MARGIN)),
        .class_o  (pix_class_s)
    );

    assign last_s = (addr_q == LAST);

    // Winner must be strictly greatest and reach the minimum count; ties give none.
    always_comb begin
        if ((wr_q > wg_q) && (wr_q > wb_q) && (wr_q >= MINC)) begin
            color_sel_s = COLOR_RED;
        end else if ((wg_q > wr_q) && (wg_q > wb_q) && (wg_q >= MINC)) begin
            color_sel_s = COLOR_GREEN;
        end else if ((wb_q > wr_q) && (wb_q > wg_q) && (wb_q >= MINC)) begin
            color_sel_s = COLOR_BLUE;
        end else begin
            color_sel_s = COLOR_NONE;
        end
    end

    // State register plus all datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wr_q    <= '0;
            wg_q    <= '0;
            wb_q    <= '0;
            cnt_r_q <= '0;
            cnt_g_q <= '0;
            cnt_b_q <= '0;
            color_q <= 2'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wg_q    <= wg_d;
            wb_q    <= wb_d;
            cnt_r_q <= cnt_r_d;
            cnt_g_q <= cnt_g_d;
            cnt_b_q <= cnt_b_d;
            color_q <= color_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SCAN: begin
                if (last_s) begin
                    state_d = ST_DECIDE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DECIDE: state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values of the address, counters and registered outputs.
    always_comb begin
        addr_d  = addr_q;
        wr_d    = wr_q;
        wg_d    = wg_q;
        wb_d    = wb_q;
        cnt_r_d = cnt_r_q;
        cnt_g_d = cnt_g_q;
        cnt_b_d = cnt_b_q;
        color_d = color_q;
        done_d  = done_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_d = '0;
                    wr_d   = '0;
                    wg_d   = '0;
                    wb_d   = '0;
                    done_d = 1'b0;
                    busy_d = 1'b1;
                end else begin
                    addr_d = '0;
                end
            end
            ST_SCAN: begin
                case (pix_class_s)
                    COLOR_RED:   wr_d = wr_q + ONE;
                    COLOR_GREEN: wg_d = wg_q + ONE;
                    COLOR_BLUE:  wb_d = wb_q + ONE;
                    default:     wr_d = wr_q;
                endcase
                if (last_s) begin
                    addr_d = '0;
                end else begin
                    addr_d = addr_q + ONE;
                end
            end
            ST_DECIDE: begin
                cnt_r_d = wr_q;
                cnt_g_d = wg_q;
                cnt_b_d = wb_q;
                color_d = color_sel_s;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                addr_d = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign proc_addr_in = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign color        = color_q;
    assign cnt_r        = cnt_r_q;
    assign cnt_g        = cnt_g_q;
    assign cnt_b        = cnt_b_q;

endmodule
